sha256_msg_mem_responder: RTL and testbench

// Memory-side responder for the simplified_sha256 core's mem_* bus; the far end of the core's master interface.
// A host streams NUM_OF_WORDS message words in. The block stores them at MSG_BASE and pulses core_start.
// It then serves the core's reads and writes with 1-cycle read latency and captures the 8 hash words written at OUT_BASE.

---
 rtl/sha256_msg_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_sha256_msg_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_mem_responder.sv
// Memory-side responder for the simplified_sha256 core's mem_* bus.
// A host streams a message into the internal word array. The block then starts the
// core, serves the core's reads and writes, keeps a copy of the 8 hash words the core
// writes, and streams those hash words back to the host.
// Ports:
//   clk, reset_n          clock (also the core's mem_clk); synchronous active-low reset
//   in_valid/in_ready/in_data          host message word stream
//   core_start/core_done               core job control
//   core_message_addr/core_output_addr constant base addresses for the core
//   core_mem_we/addr/write_data        core memory access; core_mem_read_data is registered
//   hash_valid/hash_ready/hash_data/hash_last  hash word stream back to the host
//   busy, addr_err, cycle_count        status
module sha256_msg_mem_responder #(
  parameter int unsigned NUM_OF_WORDS = 40,
  parameter int unsigned MSG_BASE     = 0,
  parameter int unsigned OUT_BASE     = 1000,
  parameter int unsigned DEPTH        = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic [31:0] core_mem_read_data,
  output logic        hash_valid,
  input  logic        hash_ready,
  output logic [31:0] hash_data,
  output logic        hash_last,
  output logic        busy,
  output logic        addr_err,
  output logic [31:0] cycle_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IDX_W = 16;
  localparam int unsigned NH    = 8;
  localparam int unsigned HW    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  word_idx, word_idx_d;
  logic [HW-1:0]     hash_idx, hash_idx_d;
  logic [31:0]       h   [NH];
  logic [31:0]       h_d [NH];
  logic [31:0]       mem [DEPTH];

  logic              accept_c;
  logic              serve_c;
  logic              oob_c;
  logic              in_h_c;
  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [31:0]       mem_wdata_c;

  assign core_message_addr = 16'(MSG_BASE);
  assign core_output_addr  = 16'(OUT_BASE);

  // Core bus is live only while the job is started or running.
  assign accept_c = in_valid & in_ready;
  assign serve_c  = (state == S_START) || (state == S_RUN);
  assign oob_c    = serve_c && (32'(core_mem_addr) >= 32'(DEPTH));
  assign in_h_c   = (32'(core_mem_addr) >= 32'(OUT_BASE)) &&
                    (32'(core_mem_addr) <= 32'(OUT_BASE + 7));

  // Next-state, index and write-port selection.
  always_comb begin
    state_d     = state;
    word_idx_d  = word_idx;
    hash_idx_d  = hash_idx;
    h_d         = h;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = '0;

    case (state)
      S_IDLE, S_LOAD: begin
        if (accept_c) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = AW'(MSG_BASE) + AW'(word_idx);
          mem_wdata_c = in_data;
          if (word_idx == IDX_W'(NUM_OF_WORDS - 1)) begin
            state_d    = S_START;
            word_idx_d = '0;
          end else begin
            state_d    = S_LOAD;
            word_idx_d = word_idx + IDX_W'(1);
          end
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (core_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hash_valid && hash_ready) begin
          if (hash_idx == HW'(NH - 1)) begin
            state_d    = S_IDLE;
            hash_idx_d = '0;
          end else begin
            hash_idx_d = hash_idx + HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Core writes; out-of-range writes are dropped. Hash-window writes are mirrored into H.
    if (serve_c && core_mem_we && !oob_c) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = AW'(core_mem_addr);
      mem_wdata_c = core_mem_write_data;
      if (in_h_c) h_d[HW'(core_mem_addr - 16'(OUT_BASE))] = core_mem_write_data;
    end
  end

  // Word array: never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // State, result registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      word_idx           <= '0;
      hash_idx           <= '0;
      for (int i = 0; i < NH; i++) h[i] <= '0;
      in_ready           <= 1'b0;
      core_start         <= 1'b0;
      busy               <= 1'b0;
      hash_valid         <= 1'b0;
      hash_last          <= 1'b0;
      hash_data          <= '0;
      core_mem_read_data <= '0;
      addr_err           <= 1'b0;
      cycle_count        <= '0;
    end else begin
      state      <= state_d;
      word_idx   <= word_idx_d;
      hash_idx   <= hash_idx_d;
      h          <= h_d;
      in_ready   <= (state_d == S_IDLE) || (state_d == S_LOAD);
      core_start <= (state_d == S_START);
      busy       <= (state_d != S_IDLE);
      hash_valid <= (state_d == S_DRAIN);
      hash_last  <= (state_d == S_DRAIN) && (hash_idx_d == HW'(NH - 1));
      hash_data  <= (state_d == S_DRAIN) ? h_d[hash_idx_d] : '0;

      // Array read happens before the same-edge write, so read-after-write sees new data next cycle.
      if (serve_c && !core_mem_we) core_mem_read_data <= oob_c ? '0 : mem[AW'(core_mem_addr)];

      // START clears the sticky error; any later out-of-range access sets it.
      if (state == S_START) addr_err <= oob_c;
      else if (oob_c)       addr_err <= 1'b1;

      if (state == S_START) cycle_count <= '0;
      else if ((state == S_RUN) && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_mem_responder.sv
// Self-checking bench for sha256_msg_mem_responder: loads a rotating-seed message,
// plays a table of core accesses, drains the hash words, then covers reset during RUN.
module tb_sha256_msg_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_start;
  logic        core_done;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_mem_we;
  logic [15:0] core_mem_addr;
  logic [31:0] core_mem_write_data;
  logic [31:0] core_mem_read_data;
  logic        hash_valid;
  logic        hash_ready;
  logic [31:0] hash_data;
  logic        hash_last;
  logic        busy;
  logic        addr_err;
  logic [31:0] cycle_count;

  sha256_msg_mem_responder dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .core_start          (core_start),
    .core_done           (core_done),
    .core_message_addr   (core_message_addr),
    .core_output_addr    (core_output_addr),
    .core_mem_we         (core_mem_we),
    .core_mem_addr       (core_mem_addr),
    .core_mem_write_data (core_mem_write_data),
    .core_mem_read_data  (core_mem_read_data),
    .hash_valid          (hash_valid),
    .hash_ready          (hash_ready),
    .hash_data           (hash_data),
    .hash_last           (hash_last),
    .busy                (busy),
    .addr_err            (addr_err),
    .cycle_count         (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] w[40];
  logic [31:0] hv[8];
  logic [31:0] exp_h[8];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic we, input logic [15:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input logic err);
    vt.push_back('{we: we, addr: a, wdata: d, exp_rd: rd, exp_err: err});
  endfunction

  // Streams the 40 message words, then steps through the START cycle.
  task automatic load_job();
    int n;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!in_ready) check("load_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      if (i == 38) check("no_start_before_last", 32'(core_start), 32'd0);
    end
    in_valid = 1'b0;
    check("start_after_last_accept", 32'(core_start), 32'd1);
    check("in_ready_low_in_start", 32'(in_ready), 32'd0);
    check("busy_in_start", 32'(busy), 32'd1);
    tick();
    check("start_one_cycle", 32'(core_start), 32'd0);
    check("addr_err_cleared_by_start", 32'(addr_err), 32'd0);
    check("cycle_count_cleared", cycle_count, 32'd0);
  endtask

  // Drains 8 hash words; mode 1 uses hash_ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode);
    int idx = 0;
    int k   = 0;
    while (idx < 8 && k < 100) begin
      if (!hash_valid) begin
        check("hash_valid_in_drain", 32'(hash_valid), 32'd1);
        break;
      end
      check($sformatf("hash_data[%0d]", idx), hash_data, exp_h[idx]);
      check($sformatf("hash_last[%0d]", idx), 32'(hash_last), 32'(idx == 7));
      hash_ready = (mode == 0) || (k % 3 == 0);
      tick();
      if (hash_ready) idx++;
      k++;
    end
    hash_ready = 1'b0;
    check("drain_word_count", 32'(idx), 32'd8);
    check("busy_after_last", 32'(busy), 32'd0);
    check("hash_valid_after_last", 32'(hash_valid), 32'd0);
    check("in_ready_after_drain", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_hash_valid"}, 32'(hash_valid), 32'd0);
    check({tag, "_hash_data"}, hash_data, 32'd0);
    check({tag, "_hash_last"}, 32'(hash_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
    check({tag, "_read_data"}, core_mem_read_data, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    core_done = 1'b0;
    core_mem_we = 1'b0;
    core_mem_addr = '0;
    core_mem_write_data = '0;
    hash_ready = 1'b0;

    w[0] = 32'h01234675;
    for (int i = 1; i < 40; i++) w[i] = {w[i-1][30:0], w[i-1][31]};
    hv[0] = 32'hDEADBEEF; hv[1] = 32'hBB67AE85; hv[2] = 32'h3C6EF372; hv[3] = 32'hA54FF53A;
    hv[4] = 32'h510E527F; hv[5] = 32'h9B05688C; hv[6] = 32'h1F83D9AB; hv[7] = 32'h12345678;

    // RUN-phase core access table: {we, addr, wdata, read_data after edge, addr_err after edge}
    for (int i = 0; i < 40; i++) add(1'b0, 16'(i), 32'd0, w[i], 1'b0);
    add(1'b1, 16'd1000, hv[0], w[39], 1'b0);
    add(1'b0, 16'd1000, 32'd0, hv[0], 1'b0);
    for (int i = 1; i < 7; i++) add(1'b1, 16'(1000 + i), hv[i], hv[0], 1'b0);
    add(1'b1, 16'd256, 32'hCAFEF00D, hv[0], 1'b0);
    add(1'b0, 16'h0900, 32'd0, 32'd0, 1'b1);
    add(1'b1, 16'h0900, 32'hBAD0BAD0, 32'd0, 1'b1);
    add(1'b0, 16'd256, 32'd0, 32'hCAFEF00D, 1'b1);
    add(1'b0, 16'd1003, 32'd0, hv[3], 1'b1);
    add(1'b1, 16'd1007, hv[7], hv[3], 1'b1);  // core_done asserted with this one

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    check("core_output_addr", 32'(core_output_addr), 32'd1000);
    check("core_message_addr", 32'(core_message_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Job 1: full load, table of core accesses, stalled drain
    load_job();
    for (int i = 0; i < vt.size(); i++) begin
      core_mem_we         = vt[i].we;
      core_mem_addr       = vt[i].addr;
      core_mem_write_data = vt[i].wdata;
      core_done           = (i == vt.size() - 1);
      tick();
      check($sformatf("read_data[%0d]", i), core_mem_read_data, vt[i].exp_rd);
      check($sformatf("addr_err[%0d]", i), 32'(addr_err), 32'(vt[i].exp_err));
    end
    core_done = 1'b0;
    core_mem_we = 1'b0;
    core_mem_addr = 16'd0;
    core_mem_write_data = 32'd0;
    check("cycle_count_run", cycle_count, 32'(vt.size()));
    check("drain_valid", 32'(hash_valid), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);

    // Core accesses during DRAIN are ignored
    tick();
    check("drain_read_ignored", core_mem_read_data, hv[3]);
    check("drain_stall_data", hash_data, hv[0]);
    core_mem_we = 1'b1;
    core_mem_addr = 16'd1001;
    tick();
    core_mem_we = 1'b0;
    core_mem_addr = 16'd0;
    check("drain_cycle_count_frozen", cycle_count, 32'(vt.size()));
    check("drain_addr_err_sticky", 32'(addr_err), 32'd1);
    for (int i = 0; i < 8; i++) exp_h[i] = hv[i];
    drain(1);

    // Job 2: reset in the middle of RUN after three hash writes
    load_job();
    for (int i = 0; i < 3; i++) begin
      core_mem_we = 1'b1;
      core_mem_addr = 16'(1000 + i);
      core_mem_write_data = 32'h0BADCAFE + 32'(i);
      tick();
    end
    core_mem_we = 1'b0;
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midrun_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_reset_quiet[%0d]", i), {29'd0, hash_valid, core_start, busy}, 32'd0);
    end

    // Job 3: immediate done; H must be zero after the reset, array must persist
    load_job();
    core_mem_addr = 16'd1000;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("array_kept_across_reset", core_mem_read_data, 32'h0BADCAFE);
    check("cycle_count_one", cycle_count, 32'd1);
    for (int i = 0; i < 8; i++) exp_h[i] = 32'd0;
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
